shared_ram_arbiter: RTL and testbench

Parametrised N-channel arbiter that time-shares one single-port synchronous RAM (1-cycle read latency) among several masters (CPU, UART RX/TX DMA, future peripherals). It replaces the fixed two-way `sel` multiplexing of the current top level with per-cycle request/grant arbitration. The arbiter supports round-robin or fixed-priority selection, locked bursts with a fairness cap, and read-data routing back to the requesting channel.

---
 rtl/shared_ram_arbiter_pkg.sv | 27 ++
 rtl/shared_ram_arbiter_picker.sv | 34 +++
 rtl/shared_ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: selection modes, state encoding and
// the width helpers used to size index and counter fields.
package ram_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Channel index width; a single channel still needs a 1-bit field.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/shared_ram_arbiter_picker.sv
// One-hot winner search over a request vector, starting at a given index and
// wrapping; fixed-priority builds force the start to channel 0.
module rr_priority_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = ARB_RR,
    parameter int IW      = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     start_i,
    output logic [NUM_CH-1:0] win_o
);

    logic [IW-1:0]     start_eff;
    logic [NUM_CH-1:0] upper;
    logic [NUM_CH-1:0] upper_win;
    logic [NUM_CH-1:0] wrap_win;

    assign start_eff = (RR_MODE == ARB_RR) ? start_i : '0;

    always_comb begin
        upper = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            upper[j] = req_i[j] && (IW'(j) >= start_eff);
        end
    end

    // Isolate the lowest set bit: requests at/after start first, else wrap.
    assign upper_win = upper & (~upper + NUM_CH'(1));
    assign wrap_win  = req_i & (~req_i + NUM_CH'(1));
    assign win_o     = (|upper) ? upper_win : wrap_win;

endmodule

// File: rtl/shared_ram_arbiter.sv
// N-channel request/grant arbiter in front of one single-port synchronous RAM,
// with locked bursts capped at MAX_BURST and read-data routing.
module shared_ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  NUM_CH    = 2,
    parameter int  ADDR_W    = 16,
    parameter int  DATA_W    = 8,
    parameter int  RR_MODE   = ARB_RR,
    parameter int  MAX_BURST = 16,
    localparam int IW        = idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        lock,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    input  logic [DATA_W-1:0]        mem_dout,
    output logic [IW-1:0]            owner,
    output logic                     busy
);

    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     lock_ch_q, lock_ch_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              cap_q, cap_d;
    logic [NUM_CH-1:0] rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] din_hold_q, din_hold_d;

    logic [NUM_CH-1:0] lock_oh;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] pick_oh;
    logic [NUM_CH-1:0] gnt_raw;
    logic [IW-1:0]     start_idx;
    logic [IW-1:0]     gnt_idx;
    logic              lock_hit;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic              sel_we;

    assign lock_oh  = NUM_CH'(1) << lock_ch_q;
    assign lock_hit = (state_q == ST_LOCKED) && (|(req & lock_oh));

    assign start_idx = (last_q == IW'(NUM_CH - 1)) ? '0 : last_q + IW'(1);

    // Right after a capped burst the previous owner steps aside if anyone else waits.
    always_comb begin
        arb_req = req;
        if (cap_q && (|(req & ~lock_oh))) begin
            arb_req = req & ~lock_oh;
        end
    end

    rr_priority_picker #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .IW      (IW)
    ) u_picker (
        .req_i   (arb_req),
        .start_i (start_idx),
        .win_o   (pick_oh)
    );

    assign gnt_raw = lock_hit ? lock_oh : pick_oh;
    assign gnt     = gnt_raw & {NUM_CH{reset}};
    assign any_gnt = |gnt;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (gnt_raw[j]) begin
                gnt_idx  = IW'(j);
                sel_addr = addr[j*ADDR_W +: ADDR_W];
                sel_din  = wdata[j*DATA_W +: DATA_W];
                sel_we   = we[j];
            end
        end
    end

    assign mem_we   = any_gnt & sel_we;
    assign mem_addr = any_gnt ? sel_addr : addr_hold_q;
    assign mem_din  = any_gnt ? sel_din : din_hold_q;
    assign rdata    = mem_dout;
    assign rvalid   = rvalid_q;
    assign owner    = owner_q;
    assign busy     = (state_q == ST_LOCKED);

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        burst_cnt_d = burst_cnt_q;
        cap_d       = 1'b0;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_hold_d = addr_hold_q;
        din_hold_d  = din_hold_q;
        rvalid_d    = gnt & ~we;

        if (any_gnt) begin
            last_d      = gnt_idx;
            owner_d     = gnt_idx;
            addr_hold_d = sel_addr;
            din_hold_d  = sel_din;
        end

        if (lock_hit) begin
            if (burst_cnt_q + CW'(1) >= CW'(MAX_BURST)) begin
                state_d     = ST_FREE;
                burst_cnt_d = '0;
                cap_d       = 1'b1;
            end else if (!(|(lock & lock_oh))) begin
                state_d     = ST_FREE;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + CW'(1);
            end
        end else if (any_gnt && (|(lock & gnt_raw))) begin
            state_d     = ST_LOCKED;
            lock_ch_d   = gnt_idx;
            burst_cnt_d = CW'(1);
        end else begin
            state_d     = ST_FREE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FREE;
            lock_ch_q   <= '0;
            burst_cnt_q <= '0;
            cap_q       <= 1'b0;
            last_q      <= IW'(NUM_CH - 1);
            owner_q     <= '0;
            rvalid_q    <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            burst_cnt_q <= burst_cnt_d;
            cap_q       <= cap_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            rvalid_q    <= rvalid_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
        end
    end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter (3 channels,
// burst cap 4) share stimulus; the round-robin one drives a small RAM model.
module tb_shared_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [23:0] wdata;

    logic [2:0]  rr_gnt, rr_rvalid;
    logic [7:0]  rr_rdata, rr_din, rr_dout;
    logic        rr_we, rr_busy;
    logic [15:0] rr_addr;
    logic [1:0]  rr_owner;

    logic [2:0]  fx_gnt, fx_rvalid;
    logic [7:0]  fx_rdata, fx_din;
    logic [7:0]  fx_dout;
    logic        fx_we, fx_busy;
    logic [15:0] fx_addr;
    logic [1:0]  fx_owner;

    logic [7:0]  mem [256];

    int n_chk;
    int n_bad;

    shared_ram_arbiter #(
        .NUM_CH(3), .ADDR_W(16), .DATA_W(8), .RR_MODE(1), .MAX_BURST(4)
    ) u_rr (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(rr_gnt), .rvalid(rr_rvalid),
        .rdata(rr_rdata), .mem_we(rr_we), .mem_addr(rr_addr),
        .mem_din(rr_din), .mem_dout(rr_dout), .owner(rr_owner), .busy(rr_busy)
    );

    shared_ram_arbiter #(
        .NUM_CH(3), .ADDR_W(16), .DATA_W(8), .RR_MODE(0), .MAX_BURST(4)
    ) u_fx (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(fx_gnt), .rvalid(fx_rvalid),
        .rdata(fx_rdata), .mem_we(fx_we), .mem_addr(fx_addr),
        .mem_din(fx_din), .mem_dout(fx_dout), .owner(fx_owner), .busy(fx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fx_dout = 8'h00;

    always @(posedge clk) begin
        if (rr_we) mem[rr_addr[7:0]] <= rr_din;
        rr_dout <= mem[rr_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] a, input logic [7:0] d);
        addr[ch*16 +: 16] = a;
        wdata[ch*8 +: 8]  = d;
    endtask

    logic [2:0] cap_gnt  [7];
    logic       cap_busy [7];
    logic [2:0] rr_seq   [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'hA5;
        rr_dout = 8'h00;
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        cap_gnt  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
        cap_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rr_seq   = '{3'b001, 3'b010, 3'b100, 3'b001};

        // reset values, and grant gating while reset is low
        @(negedge clk);
        chk("rst_gnt", rr_gnt, 3'b000);
        chk("rst_owner", rr_owner, 2'd0);
        chk("rst_busy", rr_busy, 1'b0);
        chk("rst_rvalid", rr_rvalid, 3'b000);
        chk("rst_mem_addr", rr_addr, 16'h0000);
        req = 3'b111;
        we  = 3'b111;
        #1;
        chk("rst_gnt_gated", rr_gnt, 3'b000);
        chk("rst_we_gated", rr_we, 1'b0);
        req = '0;
        we  = '0;
        nxt();
        reset = 1'b1;

        // round-robin fairness
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", k), rr_gnt, rr_seq[k]);
            if (k == 0) chk("fx_all_req", fx_gnt, 3'b001);
            if (k == 1) chk("rr_rvalid_ch0", rr_rvalid, 3'b001);
            if (k == 2) chk("rr_owner1", rr_owner, 2'd1);
            nxt();
        end
        req = '0;
        nxt();

        // fixed priority and address hold
        set_ch(1, 16'h0040, 8'h00);
        set_ch(2, 16'h0077, 8'h00);
        req = 3'b110;
        @(negedge clk);
        chk("fx_gnt_110a", fx_gnt, 3'b010);
        nxt();
        @(negedge clk);
        chk("fx_gnt_110b", fx_gnt, 3'b010);
        nxt();
        req = 3'b100;
        @(negedge clk);
        chk("fx_gnt_100", fx_gnt, 3'b100);
        nxt();
        req = '0;
        @(negedge clk);
        chk("fx_idle_gnt", fx_gnt, 3'b000);
        chk("fx_hold_addr", fx_addr, 16'h0077);
        chk("fx_idle_we", fx_we, 1'b0);
        nxt();

        // write then reads with one-cycle latency
        set_ch(0, 16'h0010, 8'h3C);
        req = 3'b001;
        we  = 3'b001;
        @(negedge clk);
        chk("wr_gnt", rr_gnt, 3'b001);
        chk("wr_mem_we", rr_we, 1'b1);
        chk("wr_mem_addr", rr_addr, 16'h0010);
        chk("wr_mem_din", rr_din, 8'h3C);
        nxt();
        set_ch(1, 16'h0040, 8'h00);
        req = 3'b010;
        we  = 3'b000;
        @(negedge clk);
        chk("rd_gnt", rr_gnt, 3'b010);
        chk("wr_no_rvalid", rr_rvalid, 3'b000);
        nxt();
        req = '0;
        @(negedge clk);
        chk("rd_rvalid", rr_rvalid, 3'b010);
        chk("rd_rdata_a5", rr_rdata, 8'hA5);
        nxt();
        set_ch(1, 16'h0010, 8'h00);
        req = 3'b010;
        nxt();
        req = '0;
        @(negedge clk);
        chk("rd2_rvalid", rr_rvalid, 3'b010);
        chk("rd2_rdata_3c", rr_rdata, 8'h3C);
        nxt();

        // burst cap of 4 with a competing requester
        req  = 3'b011;
        lock = 3'b001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("cap_rr_gnt%0d", k), rr_gnt, cap_gnt[k]);
            chk($sformatf("cap_rr_busy%0d", k), rr_busy, cap_busy[k]);
            chk($sformatf("cap_fx_gnt%0d", k), fx_gnt, cap_gnt[k]);
            nxt();
        end
        req  = '0;
        lock = '0;
        nxt();
        nxt();

        // lock release when the owner drops its request
        req  = 3'b001;
        lock = 3'b001;
        @(negedge clk);
        chk("rel_gnt_c1", rr_gnt, 3'b001);
        nxt();
        req = 3'b010;
        @(negedge clk);
        chk("rel_gnt_c2", rr_gnt, 3'b010);
        nxt();
        req  = '0;
        lock = '0;
        @(negedge clk);
        chk("rel_busy", rr_busy, 1'b0);
        chk("rel_gnt_c3", rr_gnt, 3'b000);
        nxt();

        // asynchronous reset in the middle of a locked channel-2 burst
        set_ch(2, 16'h0040, 8'hEE);
        req  = 3'b100;
        lock = 3'b100;
        @(negedge clk);
        chk("mrst_gnt_c1", rr_gnt, 3'b100);
        nxt();
        we = 3'b100;
        @(negedge clk);
        chk("mrst_gnt_c2", rr_gnt, 3'b100);
        chk("mrst_busy_c2", rr_busy, 1'b1);
        chk("mrst_rvalid_c2", rr_rvalid, 3'b100);
        chk("mrst_we_c2", rr_we, 1'b1);
        chk("mrst_owner_c2", rr_owner, 2'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("mrst_gnt", rr_gnt, 3'b000);
        chk("mrst_rvalid", rr_rvalid, 3'b000);
        chk("mrst_we", rr_we, 1'b0);
        chk("mrst_busy", rr_busy, 1'b0);
        chk("mrst_owner", rr_owner, 2'd0);
        nxt();
        reset = 1'b1;
        req   = 3'b111;
        lock  = '0;
        we    = '0;
        @(negedge clk);
        chk("post_rst_gnt", rr_gnt, 3'b001);
        nxt();
        set_ch(1, 16'h0040, 8'h00);
        req = 3'b010;
        @(negedge clk);
        chk("post_rd_gnt", rr_gnt, 3'b010);
        nxt();
        req = '0;
        @(negedge clk);
        chk("post_rd_rvalid", rr_rvalid, 3'b010);
        chk("post_rd_no_write", rr_rdata, 8'hA5);
        nxt();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
